// File: rtl/sha_block_padder.sv
// Packs a byte-wide AXI-Stream message into 512-bit big-endian blocks and
// optionally appends SHA-1/SHA-256 padding (0x80, zero fill, 64-bit bit length).
module sha_block_padder #(
  parameter int IN_BYTES = 64,
  parameter bit PAD_EN   = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  o_tready_in,
  input  logic                  i_tvalid_in,
  input  logic [8*IN_BYTES-1:0] i_tdata_in,
  input  logic [IN_BYTES-1:0]   i_tkeep_in,
  input  logic                  i_tlast_in,
  input  logic                  i_tready_out,
  output logic                  o_tvalid_out,
  output logic [511:0]          o_tdata_out,
  output logic                  o_tlast_out
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holds valid and payload stable until that edge.

  typedef enum logic {FILL, EXTRA} state_t;
  // Element 0 is the most significant byte, matching block byte order.
  typedef logic [0:63][7:0] block_t;

  state_t             state_q, state_d;
  block_t             asm_q, asm_d;
  block_t             out_data_q, out_data_d;
  logic               asm_full_q, asm_full_d;
  logic               asm_last_q, asm_last_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               extra_mark_q, extra_mark_d;
  logic [5:0]         off_q, off_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [63:0]        extra_len_q, extra_len_d;

  logic               load;
  logic               accept;
  logic [6:0]         n_bytes;
  logic [6:0]         p_end;
  logic [CNT_W-1:0]   len_sum;
  logic [63:0]        bit_len;
  logic [511:0]       data_ext;
  logic [5:0]         rel;
  block_t             extra_blk;

  assign load        = asm_full_q && (!out_valid_q || i_tready_out);
  assign o_tready_in = !reset && (state_q == FILL) && (!asm_full_q || load);
  assign accept      = i_tvalid_in && o_tready_in;

  assign o_tvalid_out = out_valid_q;
  assign o_tdata_out  = out_data_q;
  assign o_tlast_out  = out_last_q;

  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    out_data_d   = out_data_q;
    asm_full_d   = asm_full_q;
    asm_last_d   = asm_last_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    extra_mark_d = extra_mark_q;
    off_d        = off_q;
    len_d        = len_q;
    extra_len_d  = extra_len_q;
    rel          = '0;

    n_bytes = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      n_bytes = n_bytes + 7'(i_tkeep_in[i]);
    end
    p_end     = 7'(off_q) + n_bytes;
    len_sum   = len_q + CNT_W'(n_bytes);
    bit_len   = 64'(len_sum) << 3;
    data_ext  = 512'(i_tdata_in);
    extra_blk = {(extra_mark_q ? 8'h80 : 8'h00), 440'b0, extra_len_q};

    if (load) begin
      out_data_d  = asm_q;
      out_last_d  = asm_last_q;
      out_valid_d = 1'b1;
      asm_full_d  = 1'b0;
    end else if (i_tready_out) begin
      out_valid_d = 1'b0;
    end

    // The second padding block is built only once the buffer has drained.
    if (state_q == EXTRA && load) begin
      asm_d      = extra_blk;
      asm_full_d = 1'b1;
      asm_last_d = 1'b1;
      state_d    = FILL;
    end

    if (accept) begin
      if (!i_tlast_in) begin
        for (int i = 0; i < IN_BYTES; i++) begin
          asm_d[off_q + 6'(i)] = i_tdata_in[8*i +: 8];
        end
        off_d = off_q + 6'(IN_BYTES);
        len_d = len_q + CNT_W'(IN_BYTES);
        if (off_d == 6'd0) begin
          asm_full_d = 1'b1;
          asm_last_d = 1'b0;
        end
      end else begin
        for (int k = 0; k < 64; k++) begin
          rel = 6'(k) - off_q;
          if (7'(k) < 7'(off_q)) begin
            asm_d[k] = asm_q[k];
          end else if (7'(k) < p_end) begin
            asm_d[k] = data_ext[{rel, 3'b000} +: 8];
          end else if (PAD_EN && 7'(k) == p_end) begin
            asm_d[k] = 8'h80;
          end else if (PAD_EN && p_end <= 7'd55 && k >= 56) begin
            asm_d[k] = bit_len[8*(63-k) +: 8];
          end else begin
            asm_d[k] = 8'h00;
          end
        end
        asm_full_d  = 1'b1;
        off_d       = '0;
        len_d       = '0;
        extra_len_d = bit_len;
        if (PAD_EN && p_end >= 7'd56) begin
          asm_last_d   = 1'b0;
          extra_mark_d = (p_end == 7'd64);
          state_d      = EXTRA;
        end else begin
          asm_last_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FILL;
      asm_q        <= '0;
      out_data_q   <= '0;
      asm_full_q   <= 1'b0;
      asm_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      extra_mark_q <= 1'b0;
      off_q        <= '0;
      len_q        <= '0;
      extra_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      out_data_q   <= out_data_d;
      asm_full_q   <= asm_full_d;
      asm_last_q   <= asm_last_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      extra_mark_q <= extra_mark_d;
      off_q        <= off_d;
      len_q        <= len_d;
      extra_len_q  <= extra_len_d;
    end
  end

endmodule

// File: doc/sha_block_padder.md
# sha_block_padder

Parametrised successor of the SHA-1 packet aligner. It accepts a byte-wide AXI-Stream message of configurable beat width and packs it into 512-bit big-endian blocks. It optionally appends SHA-1/SHA-256 padding: 0x80, zero fill, and a 64-bit bit-length. It sits between the host/DMA stream and the SHA compression core; each output beat is one ready-to-hash block.

## Interface

- IN_BYTES, default 64: input beat width in bytes; legal values 4, 8, 16, 32, 64.
- PAD_EN, default 1: 1 = append SHA padding and length; 0 = zero-fill the final partial block only.
- CNT_W, default 32: message byte-counter width; the bit-length field is zero-extended to 64 bits.

Ports:

- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- o_tready_in  out  1  input ready.
- i_tvalid_in  in  1  input valid.
- i_tdata_in  in  8*IN_BYTES  message bytes; byte i at [8i+7:8i] is the i-th byte of the beat.
- i_tkeep_in  in  IN_BYTES  byte enables; contiguous from bit 0.
- i_tlast_in  in  1  last beat of message.
- i_tready_out  in  1  downstream ready.
- o_tvalid_out  out  1  block valid.
- o_tdata_out  out  512  block; block byte k at [511-8k:504-8k]; byte 0 is MSB.
- o_tlast_out  out  1  final block of message.

## Operation

- **Input rules**
  - Non-last beats must have i_tkeep_in all ones.
  - A tlast beat may carry n = popcount(tkeep) bytes, 0..IN_BYTES; n = 0 is legal.
  - Any other tkeep pattern is undefined.
- **State**
  - Assembly buffer: 64 bytes, plus flags asm_full and asm_last.
  - Write offset `off`: 0..63, in steps of IN_BYTES.
  - Byte count `len`: CNT_W bits, wraps mod 2^CNT_W.
  - Output register, plus FSM {FILL, EXTRA}.
- **Handshakes**
  - load = asm_full && (!o_tvalid_out || i_tready_out). On load, the output register takes the buffer and asm_last.
  - o_tready_in = (state==FILL) && (!asm_full || load).
- **FILL, non-last beat accepted:** bytes are written at `off`, off += IN_BYTES, len += IN_BYTES. When off wraps to 0, asm_full=1 and asm_last=0.
- **FILL, tlast beat accepted**, with p = off+n and L = 8*(len+n) as a 64-bit value:
  - PAD_EN=1, p<=55: byte p = 0x80, bytes p+1..55 = 0, bytes 56..63 = L big-endian. asm_last=1. State stays FILL.
  - PAD_EN=1, 56<=p<=63: byte p = 0x80, remaining bytes 0, asm_last=0. Go to EXTRA; the pending extra block is 0x00 x56 + L.
  - PAD_EN=1, p==64: data block, asm_last=0. Go to EXTRA; the pending extra block is 0x80 + 0x00 x55 + L.
  - PAD_EN=0: bytes p..63 = 0, asm_last=1. If p==0, an all-zero block with tlast is emitted.
  - In every case asm_full=1, off=0, len=0.
- **EXTRA:** o_tready_in=0. On load, the buffer takes the extra block with asm_full=1 and asm_last=1, and state returns to FILL.
- The output register holds o_tdata_out and o_tlast_out stable while o_tvalid_out && !i_tready_out.
- **Reset:** state=FILL, off=0, len=0, asm_full=0. Outputs: o_tvalid_out=0, o_tdata_out=0, o_tlast_out=0, o_tready_in=0 while reset is high. Any partial message is discarded.

## Timing

- A beat completing a block is accepted at edge N. load happens at edge N+1 if the output is free, so o_tvalid_out is high from edge N+1: 1-cycle latency.
- Full throughput (1 block per 64/IN_BYTES input beats) is sustained when i_tready_out=1, including IN_BYTES=64. A beat may be accepted in the same cycle as load.
- Two-block finish: the final data block loads at edge M and the extra block loads at the first handshake after M; tvalid has no gap if i_tready_out=1. o_tready_in is 0 while in EXTRA.
- The next message's first beat can be accepted in the cycle after the last block of the previous message enters the assembly buffer.
- Deasserting i_tvalid_in mid-block leaves `off` and `len` unchanged.

## Test plan

- **"abc", PAD_EN=1, IN_BYTES=4.** Stimulus: one beat, tdata=0x00636261, tkeep=0111, tlast=1.
  Response: one block with [511:480]=0x61626380 and [63:0]=0x18, all else 0; tlast=1; o_tvalid_out high 1 cycle after the accept edge.
- **55 / 56 / 64-byte messages, IN_BYTES=8.**
  - 55 bytes: one block, byte 55=0x80, length 0x1B8.
  - 56 bytes: data block + 0x80 (tlast=0), then zeros + 0x1C0 (tlast=1).
  - 64 bytes: data block (tlast=0), then 0x80, zeros, 0x200 (tlast=1).
- **Throughput, IN_BYTES=64, PAD_EN=1, i_tready_out=1.** Stimulus: back-to-back 3-beat messages.
  Response: o_tready_in never drops except in EXTRA; the blocks match a golden SHA padding model.
- **Backpressure.** Stimulus: i_tready_out=0 for 10 cycles mid-message, IN_BYTES=16.
  Response: o_tdata_out stable; o_tready_in=0 once the buffer is full; no byte lost or duplicated after release.
- **PAD_EN=0, IN_BYTES=32.** Stimulus: 40-byte message, then an empty tlast beat at a block boundary.
  Response: the 40-byte block has bytes 40..63=0 and tlast=1; the empty beat produces an all-zero block with tlast=1.
- **Reset mid-operation.** Stimulus: assert reset for 1 cycle after 3 beats of a message, then send "abc".
  Response: all outputs 0 during reset; only the "abc" block with length 0x18 appears afterwards.
